// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
//   Moves one 128-bit cache line between L2 and the main memory chip per
//   request handshake. Each line travels as two 64-bit beats on the memory's
//   shared bidirectional bus. Supports fill, writeback, and
//   writeback-then-fill.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_op            00 fill, 01 writeback, 10 writeback-then-fill, 11 = fill
//   req_addr          fill line address
//   req_wb_addr       writeback line address
//   req_wdata         writeback line, [63:0] is beat 0
//   resp_valid        one-cycle completion pulse
//   resp_rdata        last filled line, held until the next fill completes
//   mem_cs/mem_ce     chip select / enable, driven together
//   mem_rw            1 read, 0 write
//   mem_addr          {line, beat, 3'b000}
//   mem_data          bidirectional data bus, driven only on write beats
module mem_line_ctrl #(
    parameter int LINE_AW = 19,
    parameter int ADDR_W  = LINE_AW + 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [LINE_AW-1:0] req_addr,
    input  logic [LINE_AW-1:0] req_wb_addr,
    input  logic [127:0]       req_wdata,
    output logic               resp_valid,
    output logic [127:0]       resp_rdata,
    output logic               mem_cs,
    output logic               mem_ce,
    output logic               mem_rw,
    output logic [ADDR_W-1:0]  mem_addr,
    inout  wire  [63:0]        mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BEAT,
        S_RD_ISSUE,
        S_RD_HOLD,
        S_RESP
    } state_e;

    localparam logic [1:0] OP_FILL   = 2'b00;
    localparam logic [1:0] OP_WB     = 2'b01;
    localparam logic [1:0] OP_WBFILL = 2'b10;

    state_e             state_q, state_d;
    logic               beat_q, beat_d;
    logic [1:0]         op_q, op_d;
    logic [LINE_AW-1:0] addr_q, addr_d;
    logic [LINE_AW-1:0] wb_addr_q, wb_addr_d;
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       rdata_q, rdata_d;

    logic               wr_drive;
    logic [63:0]        wr_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= 1'b0;
            op_q      <= OP_FILL;
            addr_q    <= '0;
            wb_addr_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next state plus output decode; outputs depend on registered state only.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wb_addr_d = wb_addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_cs     = 1'b0;
        mem_ce     = 1'b0;
        mem_rw     = 1'b1;
        mem_addr   = '0;
        wr_drive   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // op 11 is folded into a plain fill at latch time
                    op_d      = (req_op == 2'b11) ? OP_FILL : req_op;
                    addr_d    = req_addr;
                    wb_addr_d = req_wb_addr;
                    wdata_d   = req_wdata;
                    beat_d    = 1'b0;
                    if (req_op == OP_WB || req_op == OP_WBFILL)
                        state_d = S_WR_BEAT;
                    else
                        state_d = S_RD_ISSUE;
                end
            end
            S_WR_BEAT: begin
                mem_cs   = 1'b1;
                mem_ce   = 1'b1;
                mem_rw   = 1'b0;
                mem_addr = {wb_addr_q, beat_q, 3'b000};
                wr_drive = 1'b1;
                if (!beat_q) begin
                    beat_d = 1'b1;
                end else begin
                    beat_d  = 1'b0;
                    state_d = (op_q == OP_WBFILL) ? S_RD_ISSUE : S_RESP;
                end
            end
            S_RD_ISSUE: begin
                mem_cs   = 1'b1;
                mem_ce   = 1'b1;
                mem_addr = {addr_q, beat_q, 3'b000};
                state_d  = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                mem_cs   = 1'b1;
                mem_ce   = 1'b1;
                mem_addr = {addr_q, beat_q, 3'b000};
                if (beat_q) begin
                    rdata_d[127:64] = mem_data;
                    beat_d          = 1'b0;
                    state_d         = S_RESP;
                end else begin
                    rdata_d[63:0] = mem_data;
                    beat_d        = 1'b1;
                    state_d       = S_RD_ISSUE;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = 1'b0;
            end
        endcase
    end

    assign wr_word    = beat_q ? wdata_q[127:64] : wdata_q[63:0];
    assign mem_data   = wr_drive ? wr_word : 'z;
    assign resp_rdata = rdata_q;

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Line-transfer controller between the L2 cache and the 500K×16-byte main memory chip. Accepts one 128-bit line request per handshake (fill, writeback, or writeback-then-fill), splits it into two 64-bit beats on the memory's shared bidirectional bus, and returns the assembled line to L2. Sits directly upstream of the memory chip and owns its cs/ce/rw/addr pins and the write side of its data bus.

## Interface

- LINE_AW, 19, line address width (memory depth 2^19 lines)
- ADDR_W, 23, memory byte-address width; equals LINE_AW+4
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  L2 request strobe
- req_ready  out  1  high only in IDLE; request accepted on posedge with req_valid&req_ready
- req_op  in  2  00 fill, 01 writeback, 10 writeback-then-fill, 11 treated as 00
- req_addr  in  LINE_AW  fill line address
- req_wb_addr  in  LINE_AW  writeback line address (ops 01, 10)
- req_wdata  in  128  writeback line; [63:0] is beat 0, [127:64] beat 1
- resp_valid  out  1  one-cycle pulse: operation complete
- resp_rdata  out  128  filled line; holds value until next fill completes
- mem_cs, mem_ce  out  1  chip select / chip enable, driven together
- mem_rw  out  1  1 read, 0 write
- mem_addr  out  ADDR_W  {line, beat, 3'b000}
- mem_data  inout  64  driven only during write beats, else high-Z

## Operation

- States: IDLE, WR_BEAT, RD_ISSUE, RD_HOLD, RESP. 1-bit beat counter.
- Acceptance latches op, both addresses and wdata; later input changes are ignored until the next IDLE.
- IDLE: mem_cs=mem_ce=0, mem_rw=1, mem_addr=0, bus high-Z, req_ready=1. On accept: op 01/10 → WR_BEAT beat 0; op 00/11 → RD_ISSUE beat 0.
- WR_BEAT: cs=ce=1, rw=0, addr={wb_addr,beat,000}, bus = wdata half for that beat. Beat 0 → WR_BEAT beat 1; beat 1 → RD_ISSUE beat 0 (op 10) or RESP (op 01).
- RD_ISSUE: cs=ce=1, rw=1, addr={addr,beat,000}, bus released. → RD_HOLD.
- RD_HOLD: same pins held; at posedge ending this state capture mem_data into resp_rdata half for that beat. Beat 0 → RD_ISSUE beat 1; beat 1 → RESP.
- RESP: cs=ce=0, bus high-Z, resp_valid=1, req_ready=0. → IDLE.
- resp_rdata updated only by fill beats; writeback-only leaves it unchanged. Half-updated lines are never flagged valid.
- Memory RDY is a half-cycle pulse and is not used; all beat timing is fixed.

## Timing

- Reset (any state, any cycle): state=IDLE, beat=0, resp_valid=0, resp_rdata=0, mem_cs=mem_ce=0, mem_rw=1, mem_addr=0, mem_data high-Z, req_ready=1. Reset mid-beat abandons the transfer; no resp_valid.
- All mem_* outputs and req_ready are decoded from registered state only (no combinational path from req_* inputs).
- Cycle counts after the accept edge: fill: 4 bus cycles, resp_valid in cycle 5. Writeback: 2 bus cycles, resp_valid in cycle 3. Writeback-then-fill: 6 bus cycles, resp_valid in cycle 7.
- req_ready returns high the cycle after resp_valid. Minimum accept-to-accept spacing: 6 / 4 / 8 cycles.
- Write→read turnaround: controller releases the bus in the same cycle it drives rw=1. No dead cycle is required.
- req_valid while req_ready=0 is ignored, not queued.

## Test plan

- Preload memory line 0x00012 = {64'hBBBB…, 64'hAAAA…}; fill 0x00012 → addr 0x000120 then 0x000128 (each rw=1 for 2 cycles); resp_valid in cycle 5; resp_rdata = {BBBB…, AAAA…}.
- Writeback to 0x7FFFF with wdata {64'h2, 64'h1} → two write cycles at 0x7FFFF0 and 0x7FFFF8; resp_valid in cycle 3; resp_rdata unchanged; backdoor readback = {2, 1}.
- Writeback-then-fill, wb=0x00005 and fill=0x00005 → readback returns the just-written data; resp_valid in cycle 7; no bus contention (no X on mem_data).
- req_valid held high throughout plus op 11 → one fill per handshake; req_ready low for exactly 5 cycles; second request's fields are latched only at the next accept.
- Assert rst during RD_HOLD of beat 1 → same cycle: cs=0, bus Z, resp_rdata=0; no resp_valid; the next fill completes normally.
- Fill at line 0 and line 0x7FFFF → address boundaries correct (0x000000/0x000008, 0x7FFFF0/0x7FFFF8).
